// File: rtl/keypad_pkg.sv
// Shared keypad geometry, key-code constants and the row/column to key-code map.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'h0;

    // Rows 0..2 carry digits 1..9 in reading order; the bottom row is *, 0, #.
    function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad pin lines (R, C) and the decoded key outputs (N, V, P) as one bundle.
interface keypad_scan_encoder_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] R;
    logic [NUM_COLS-1:0] C;
    logic [3:0]          N;
    logic                V;
    logic                P;

    modport master (output R, output C, input N, input V, input P);
    modport slave  (input R, input C, output N, output V, output P);

endinterface

// File: rtl/keypad_sync.sv
// Multi-stage flip-flop synchronizer, cleared to zero by the asynchronous reset.
module keypad_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg[gi] <= '0;
                end else if (gi == 0) begin
                    stage_reg[gi] <= d;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x3 keypad encoder: synchronize R/C, decode a single pressed key, register N/V/P.
// Define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_CYCLES identical decodes before outputs update.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_scan_encoder_if.slave  bus
);

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("SYNC_STAGES must be in 1..3");
        end
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES must be in 1..255");
        end
    endgenerate

    logic [NUM_ROWS+NUM_COLS-1:0] sync_rc;
    logic [NUM_ROWS-1:0]          sync_r;
    logic [NUM_COLS-1:0]          sync_c;

    keypad_sync #(
        .WIDTH  (NUM_ROWS + NUM_COLS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.R, bus.C}),
        .q     (sync_rc)
    );

    assign sync_r = sync_rc[NUM_ROWS+NUM_COLS-1:NUM_COLS];
    assign sync_c = sync_rc[NUM_COLS-1:0];

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       dec_valid;
    logic [3:0] dec_code;

    always_comb begin
        row_idx   = 2'd0;
        col_idx   = 2'd0;
        dec_code  = KEY_NONE;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (sync_r[i]) row_idx = 2'(i);
        end
        for (int i = 0; i < NUM_COLS; i++) begin
            if (sync_c[i]) col_idx = 2'(i);
        end
        dec_valid = $onehot(sync_r) && $onehot(sync_c);
        if (dec_valid) dec_code = key_code(row_idx, col_idx);
    end

    logic update_en;

`ifdef KEYPAD_DEBOUNCE_EN
    logic [4:0] prev_dec_reg;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    // Count of consecutive cycles the decode has held its current value, saturating at 255.
    always_comb begin
        cnt_next = 8'd1;
        if ({dec_valid, dec_code} == prev_dec_reg) begin
            cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dec_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            prev_dec_reg <= {dec_valid, dec_code};
            cnt_reg      <= cnt_next;
        end
    end

    assign update_en = (cnt_next >= 8'(DEBOUNCE_CYCLES));
`else
    assign update_en = 1'b1;
`endif

    logic [3:0] n_reg;
    logic       v_reg;
    logic       p_reg;

    // Re-loading an unchanged decode leaves V/N as they are and keeps P low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= KEY_NONE;
            v_reg <= 1'b0;
            p_reg <= 1'b0;
        end else if (update_en) begin
            n_reg <= dec_code;
            v_reg <= dec_valid;
            p_reg <= dec_valid && (!v_reg || (n_reg != dec_code));
        end else begin
            p_reg <= 1'b0;
        end
    end

    assign bus.N = n_reg;
    assign bus.V = v_reg;
    assign bus.P = p_reg;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Randomized and directed bench for keypad_scan_encoder against a history-window reference model.
module tb_keypad_scan_encoder;

    localparam int S = 2;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_encoder_if kif();

    keypad_scan_encoder #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] hist [$];
    logic [3:0] exp_n = 4'd0;
    logic       exp_v = 1'b0;
    logic       exp_p = 1'b0;
    int         p_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // {valid, code}: exactly one row and one column, digits by keypad position, * = 10, # = 11.
    function automatic logic [4:0] ref_decode(input logic [6:0] rc);
        logic [3:0] r;
        logic [2:0] c;
        int row, col, code;
        r = rc[6:3];
        c = rc[2:0];
        if ($countones(r) != 1 || $countones(c) != 1) return 5'd0;
        row = 0;
        col = 0;
        for (int i = 0; i < 4; i++) if (r[i]) row = i;
        for (int i = 0; i < 3; i++) if (c[i]) col = i;
        if (row < 3)       code = row * 3 + col + 1;
        else if (col == 0) code = 10;
        else if (col == 1) code = 0;
        else               code = 11;
        return {1'b1, 4'(code)};
    endfunction

    // Input seen k cycles before the one currently reaching the decoder; before reset release it is no-key.
    function automatic logic [6:0] hist_at(input int k);
        int p;
        p = hist.size() - 1 - S - k;
        if (p < 0) return 7'd0;
        return hist[p];
    endfunction

    task automatic tick();
        logic [4:0] d0;
        bit stable;
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
            exp_n = 4'd0;
            exp_v = 1'b0;
            exp_p = 1'b0;
        end else begin
            hist.push_back({kif.R, kif.C});
            d0 = ref_decode(hist_at(0));
            stable = 1'b1;
            for (int k = 1; k < DB; k++) begin
                if (ref_decode(hist_at(k)) != d0) stable = 1'b0;
            end
            exp_p = 1'b0;
            if (stable) begin
                exp_p = d0[4] && (!exp_v || exp_n != d0[3:0]);
                exp_v = d0[4];
                exp_n = d0[3:0];
            end
        end
        #1;
        check("N", 32'(kif.N), 32'(exp_n));
        check("V", 32'(kif.V), 32'(exp_v));
        check("P", 32'(kif.P), 32'(exp_p));
        if (kif.P === 1'b1) p_seen++;
    endtask

    task automatic apply(input logic [3:0] r, input logic [2:0] c, input int cycles);
        kif.R = r;
        kif.C = c;
        $display("apply R=%b C=%b cycles=%0d", r, c, cycles);
        repeat (cycles) tick();
    endtask

    initial begin
        int lat;
        logic [3:0] rr;
        logic [2:0] cc;

        // Reset held with a key already down: outputs must stay cleared.
        kif.R = 4'b0010;
        kif.C = 3'b010;
        rst_n = 1'b0;
        repeat (3) tick();

        rst_n = 1'b1;
        p_seen = 0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (kif.V === 1'b1) lat = i;
        end
        check("latency_after_reset", 32'(lat), 32'(S + DB));
        check("N_after_reset", 32'(kif.N), 32'd5);
        repeat (8) tick();
        check("p_pulses_after_reset", 32'(p_seen), 32'd1);

        // Key sequence: 5, 0, #, each held 10 cycles.
        apply(4'b0010, 3'b010, 10);
        check("key5", 32'(kif.N), 32'd5);
        p_seen = 0;
        apply(4'b1000, 3'b010, 10);
        check("key0", 32'(kif.N), 32'd0);
        check("key0_valid", 32'(kif.V), 32'd1);
        check("key0_strobe", 32'(p_seen), 32'd1);
        p_seen = 0;
        apply(4'b1000, 3'b100, 10);
        check("keyhash", 32'(kif.N), 32'd11);
        check("keyhash_strobe", 32'(p_seen), 32'd1);

        // Release must not strobe.
        p_seen = 0;
        apply(4'b0000, 3'b000, 10);
        check("release_valid", 32'(kif.V), 32'd0);
        check("release_strobe", 32'(p_seen), 32'd0);

        // Multiple presses are invalid.
        apply(4'b0001, 3'b011, 10);
        check("multi_col", 32'(kif.V), 32'd0);
        apply(4'b0011, 3'b001, 10);
        check("multi_row", 32'(kif.V), 32'd0);

        // Every one-hot row/column pair.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                rr = 4'b0001 << r;
                cc = 3'b001 << c;
                apply(rr, cc, 8);
                check("sweep_valid", 32'(kif.V), 32'd1);
            end
        end
        apply(4'b0000, 3'b000, 8);

        // Short glitch of a key: shorter than the debounce window when debounce is enabled.
        apply(4'b0010, 3'b010, 2);
        apply(4'b0000, 3'b000, 10);

        // Asynchronous reset while a key is decoded.
        apply(4'b0100, 3'b100, 8);
        rst_n = 1'b0;
        #1;
        check("async_rst_N", 32'(kif.N), 32'd0);
        check("async_rst_V", 32'(kif.V), 32'd0);
        check("async_rst_P", 32'(kif.P), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        p_seen = 0;
        repeat (10) tick();
        check("rst_recover_N", 32'(kif.N), 32'd9);
        check("rst_recover_strobe", 32'(p_seen), 32'd1);

        // Random segments: mostly single keys, some multi-press and idle.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 3) != 0) begin
                rr = 4'b0001 << $urandom_range(0, 3);
                cc = 3'b001 << $urandom_range(0, 2);
            end else begin
                rr = 4'($urandom_range(0, 15));
                cc = 3'($urandom_range(0, 7));
            end
            apply(rr, cc, int'($urandom_range(1, 8)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
